// File: rtl/bemc_pkg.sv
// Shared constants for the bus encoding-mode controller.
// Holds the bus mode codes, the cost accumulator width rule and the FSM state encoding.
// Optional hysteresis (macro BEMC_HYST_EN) is applied in bus_enc_mode_ctrl, not here.
package bemc_pkg;

  // Bus modes as seen by the encoder/decoder pair; 2'd3 is reserved
  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_BI  = 2'd1;
  localparam logic [1:0] MODE_T0  = 2'd2;

  // Controller FSM encoding
  localparam logic [1:0] ST_MEASURE = 2'd0;
  localparam logic [1:0] ST_DECIDE  = 2'd1;
  localparam logic [1:0] ST_REQ     = 2'd2;

  // A window of 2^win_log2 samples costs at most 9 transitions each
  function automatic int cost_w(input int win_log2);
    return win_log2 + 4;
  endfunction

endpackage

// File: rtl/popcnt9.sv
// 9-bit population count, used to cost one bus transition (data bits plus the side bit).
// Latency: purely combinational.
// No handshake; the result follows the input.
module popcnt9 (
  input  logic [8:0] d,
  output logic [3:0] cnt
);

  // Add up the set bits
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + {3'b000, d[i]};
    end
  end

endmodule

// File: rtl/bus_enc_mode_ctrl.sv
// Adaptive bus encoding-mode controller: costs binary / bus-invert / T0 over a sample window
// and switches the encoder/decoder pair to the cheapest code via a mode_req/mode_ack handshake.
// Latency: request registered 2 edges after the window-closing sample; never stalls sampling.
// Optional hysteresis: define BEMC_HYST_EN to require a HYST-transition margin before switching.
module bus_enc_mode_ctrl
  import bemc_pkg::*;
#(
  parameter int WIN_LOG2 = 4,
  parameter int HYST     = 2
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic [1:0] mode,
  output logic [1:0] mode_next,
  output logic       mode_req,
  input  logic       mode_ack,
  output logic       overrun
);

  localparam int CW = cost_w(WIN_LOG2);

`ifdef BEMC_HYST_EN
  localparam int MARGIN = HYST;
`else
  // Plain minimum selection: any strictly cheaper code wins, HYST has no effect
  localparam int MARGIN = 0 * HYST;
`endif

  logic [7:0]          a_prev;
  logic [8:0]          bi_prev, t0_prev;
  logic [8:0]          bi_new, t0_new;
  logic [3:0]          h_bi, cost_bin, cost_bi, cost_t0;
  logic [CW-1:0]       acc_bin, acc_bi, acc_t0;
  logic [CW-1:0]       snap_bin, snap_bi, snap_t0;
  logic [CW-1:0]       best_cost, cur_cost;
  logic [1:0]          best;
  logic [1:0]          state;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_end, switch_ok;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [3:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-3){1'b0}}, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  popcnt9 u_pc_h   (.d({1'b0, in_data ^ bi_prev[7:0]}), .cnt(h_bi));
  popcnt9 u_pc_bin (.d({1'b0, in_data ^ a_prev}),       .cnt(cost_bin));
  popcnt9 u_pc_bi  (.d(bi_new ^ bi_prev),               .cnt(cost_bi));
  popcnt9 u_pc_t0  (.d(t0_new ^ t0_prev),               .cnt(cost_t0));

  // Candidate bus words for the bus-invert and T0 models
  always_comb begin
    bi_new = (h_bi > 4'd4) ? {1'b1, ~in_data} : {1'b0, in_data};
    t0_new = (in_data == a_prev + 8'd1) ? {1'b1, t0_prev[7:0]} : {1'b0, in_data};
  end

  assign win_end = in_valid && (win_cnt == {WIN_LOG2{1'b1}});

  // Bus models advance on every valid sample
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      a_prev  <= '0;
      bi_prev <= '0;
      t0_prev <= '0;
    end else if (in_valid) begin
      a_prev  <= in_data;
      bi_prev <= bi_new;
      t0_prev <= t0_new;
    end
  end

  // Window counting, accumulation and end-of-window snapshot; overrun flags a window lost in REQ
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      acc_bin  <= '0;
      acc_bi   <= '0;
      acc_t0   <= '0;
      snap_bin <= '0;
      snap_bi  <= '0;
      snap_t0  <= '0;
      overrun  <= 1'b0;
    end else if (in_valid) begin
      win_cnt <= win_cnt + WIN_LOG2'(1);
      if (win_end) begin
        acc_bin <= '0;
        acc_bi  <= '0;
        acc_t0  <= '0;
        if (state == ST_REQ) begin
          overrun <= 1'b1;
        end else begin
          snap_bin <= sat_add(acc_bin, cost_bin);
          snap_bi  <= sat_add(acc_bi, cost_bi);
          snap_t0  <= sat_add(acc_t0, cost_t0);
        end
      end else begin
        acc_bin <= sat_add(acc_bin, cost_bin);
        acc_bi  <= sat_add(acc_bi, cost_bi);
        acc_t0  <= sat_add(acc_t0, cost_t0);
      end
    end
  end

  // Cheapest code (ties favour the lower mode index) and whether it beats the current one
  always_comb begin
    best      = MODE_BIN;
    best_cost = snap_bin;
    if (snap_bi < best_cost) begin
      best      = MODE_BI;
      best_cost = snap_bi;
    end
    if (snap_t0 < best_cost) begin
      best      = MODE_T0;
      best_cost = snap_t0;
    end
    case (mode)
      MODE_BI: cur_cost = snap_bi;
      MODE_T0: cur_cost = snap_t0;
      default: cur_cost = snap_bin;
    endcase
    switch_ok = ({1'b0, best_cost} + (CW+1)'(MARGIN)) < {1'b0, cur_cost};
  end

  // Decision and mode-change handshake
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= ST_MEASURE;
      mode      <= MODE_BIN;
      mode_next <= MODE_BIN;
      mode_req  <= 1'b0;
    end else begin
      case (state)
        ST_MEASURE: if (win_end) state <= ST_DECIDE;
        ST_DECIDE: begin
          if (switch_ok) begin
            mode_next <= best;
            mode_req  <= 1'b1;
            state     <= ST_REQ;
          end else begin
            state <= ST_MEASURE;
          end
        end
        ST_REQ: begin
          if (mode_ack) begin
            mode     <= mode_next;
            mode_req <= 1'b0;
            state    <= ST_MEASURE;
          end
        end
        default: state <= ST_MEASURE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_enc_mode_ctrl.sv
// Directed bench for bus_enc_mode_ctrl: one-window vectors from a table, then the
// overrun and reset-during-request sequences.
module tb_bus_enc_mode_ctrl;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] mode, mode_next;
  logic       mode_req, mode_ack = 1'b0;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  bus_enc_mode_ctrl dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .mode_next(mode_next), .mode_req(mode_req),
    .mode_ack(mode_ack), .overrun(overrun)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [15:0][7:0] words;
    logic             exp_req;
    logic [1:0]       exp_next;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    mode_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic feed_ramp(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Vector table: ramp, alternating, constant, zeros then 0x1F
    for (int i = 0; i < 16; i++) begin
      vecs[0].words[i] = 8'(i);
      vecs[1].words[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
      vecs[2].words[i] = 8'h5A;
      vecs[3].words[i] = (i == 15) ? 8'h1F : 8'h00;
    end
    vecs[0].exp_req = 1'b1; vecs[0].exp_next = 2'd2;
    vecs[1].exp_req = 1'b1; vecs[1].exp_next = 2'd1;
    vecs[2].exp_req = 1'b0; vecs[2].exp_next = 2'd0;
`ifdef BEMC_HYST_EN
    vecs[3].exp_req = 1'b0; vecs[3].exp_next = 2'd0;
`else
    vecs[3].exp_req = 1'b1; vecs[3].exp_next = 2'd1;
`endif

    // Reset values, checked while rst is still asserted
    #2;
    chk("rst_mode", {6'd0, mode}, 8'd0);
    chk("rst_mode_next", {6'd0, mode_next}, 8'd0);
    chk("rst_mode_req", {7'd0, mode_req}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        in_valid = 1'b1;
        in_data  = vecs[v].words[i];
        step();
      end
      in_valid = 1'b0;
      // DECIDE cycle: nothing requested yet
      chk($sformatf("v%0d_req_decide", v), {7'd0, mode_req}, 8'd0);
      step();
      chk($sformatf("v%0d_req", v), {7'd0, mode_req}, {7'd0, vecs[v].exp_req});
      chk($sformatf("v%0d_next", v), {6'd0, mode_next}, {6'd0, vecs[v].exp_next});
      // Ack: applies when requesting, ignored otherwise
      mode_ack = 1'b1;
      step();
      mode_ack = 1'b0;
      chk($sformatf("v%0d_mode_after_ack", v), {6'd0, mode},
          vecs[v].exp_req ? {6'd0, vecs[v].exp_next} : 8'd0);
      chk($sformatf("v%0d_req_after_ack", v), {7'd0, mode_req}, 8'd0);
    end

    // Overrun: two ramp windows back to back with ack held low
    do_reset();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      if (i == 16) begin
        chk("ovr_req_first", {7'd0, mode_req}, 8'd1);
        chk("ovr_clear_first", {7'd0, overrun}, 8'd0);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("ovr_set", {7'd0, overrun}, 8'd1);
    chk("ovr_req_held", {7'd0, mode_req}, 8'd1);
    chk("ovr_next_held", {6'd0, mode_next}, 8'd2);
    chk("ovr_mode_held", {6'd0, mode}, 8'd0);
    mode_ack = 1'b1;
    step();
    mode_ack = 1'b0;
    chk("ovr_mode_ack", {6'd0, mode}, 8'd2);
    chk("ovr_sticky", {7'd0, overrun}, 8'd1);
    chk("ovr_req_drop", {7'd0, mode_req}, 8'd0);

    // Reset while requesting (with overrun already set)
    do_reset();
    feed_ramp(32);
    chk("rr_req_pre", {7'd0, mode_req}, 8'd1);
    chk("rr_ovr_pre", {7'd0, overrun}, 8'd1);
    rst = 1'b1;
    #2;
    chk("rr_req", {7'd0, mode_req}, 8'd0);
    chk("rr_mode", {6'd0, mode}, 8'd0);
    chk("rr_next", {6'd0, mode_next}, 8'd0);
    chk("rr_ovr", {7'd0, overrun}, 8'd0);
    step();
    rst = 1'b0;
    step();
    mode_ack = 1'b1;
    step();
    mode_ack = 1'b0;
    chk("rr_ack_mode", {6'd0, mode}, 8'd0);
    chk("rr_ack_req", {7'd0, mode_req}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
